dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed data memory (256 B, little-endian).
- Port 0: core load/store stage. Port 1: program loader / debug port.
- Arbitrates, registers the winning request, and drives the memory's enable/address/wdata/load-store controls for exactly one access cycle.
- Returns a registered response to the winning port. One transaction outstanding at a time.

Parameters:
- DEPTH, 256, memory size in bytes.
- ADDR_W, 32, address width.
- STARVE_LIMIT, 4, consecutive cycles port 1 may be denied while requesting before it is forced to win.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- pN_req_valid  in  1  request valid, port N (N=0,1).
- pN_req_ready  out  1  request accepted this cycle.
- pN_addr  in  ADDR_W  byte address.
- pN_wdata  in  32  store data (low bytes significant).
- pN_we  in  1  1 = store, 0 = load.
- pN_dw  in  2  width: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
- pN_sign  in  1  sign-extend load result.
- pN_rsp_valid  out  1  response valid.
- pN_rsp_ready  in  1  response consumed.
- pN_rsp_rdata  out  32  load data, already masked/extended by memory; 0 for stores.
- pN_rsp_err  out  1  error flag (see Optional Feature; else constant 0).
- mem_en  out  1  memory enable.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  32  registered store data.
- mem_l  out  1  load strobe.
- mem_s  out  1  store strobe.
- mem_dw  out  2  width to memory.
- mem_sign  out  1  sign to memory.
- mem_rdata  in  32  combinational memory read data.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset → IDLE. Reset values: all outputs 0, starve counter 0, owner 0.
- IDLE: arbitrate among valid requests.
  - Port 0 wins by fixed priority unless starve_cnt == STARVE_LIMIT, in which case port 1 wins.
  - Winner gets req_ready=1 combinationally in the same cycle. Loser gets ready=0.
  - On the edge: capture addr/wdata/we/dw/sign/owner; go to ACCESS.
  - No valid request: stay in IDLE, ready=0 on both ports.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each cycle port 1 is valid and not granted, in any state.
  - Clears to 0 when port 1 is granted or p1_req_valid=0.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_l=~we; mem_s=we; mem_addr/mem_wdata/mem_dw/mem_sign from the captured registers.
  - The store commits on the memory's negedge within this cycle.
  - At posedge: rdata_q ← we ? 0 : mem_rdata; go to RESP.
- RESP:
  - owner's rsp_valid=1 with rsp_rdata=rdata_q. mem_en/mem_l/mem_s=0.
  - Hold valid and data stable until owner's rsp_ready=1, then go to IDLE.
  - req_ready=0 on both ports while in ACCESS or RESP.
- Latency: accept edge → rsp_valid visible 2 cycles later (min 3-cycle throughput per transaction).
- Non-owner rsp_valid always 0.
- pN_dw=3 is forwarded to memory as 2.
- Address wrap: none; the address is passed through unmodified. Overflow handling is only in the optional feature.
- Simultaneous valid on both ports at starve_cnt < STARVE_LIMIT: port 0 granted.
- rsp_ready asserted before rsp_valid: ignored.
- rst asserted in ACCESS: memory strobes deasserted from the next cycle. A store whose negedge already occurred is not rolled back.
- rst asserted in RESP: pending response dropped; rsp_valid=0 after the edge.
- Requests must hold stable while valid && !ready. The arbiter does not buffer unaccepted requests.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - In IDLE, the captured request is flagged err if addr + bytes(dw) > DEPTH, or if addr is misaligned for the width (half: addr[0]; word: addr[1:0] != 0).
  - An err transaction skips the memory: no mem_en/mem_l/mem_s, but still spends one cycle in ACCESS for identical latency.
  - It responds with rsp_err=1 and rsp_rdata=0.
- Undefined: pN_rsp_err tied 0; no checks; all accesses go to memory.

Test Plan:
- Single store then load, port 0:
  - Stimulus: store addr 0x10, wdata 0xDEADBEEF, dw=2; then load addr 0x10, dw=2.
  - Response: mem_s pulses exactly 1 cycle; p0_rsp_valid 2 cycles after accept; load rdata=0xDEADBEEF.
- Sign handling: after the store above, load addr 0x10, dw=0, sign=1 → rdata=0xFFFFFFEF. Same with sign=0 → 0x000000EF.
- Contention/starvation, STARVE_LIMIT=4:
  - Stimulus: p0 and p1 valid every cycle.
  - Response: p0 wins while starve_cnt<4; once starve_cnt reaches 4, p1 is granted at the next IDLE arbitration. starve_cnt returns to 0 after the p1 grant.
- Response backpressure: p0 load with p0_rsp_ready held 0 for 5 cycles → rsp_valid and rdata stable all 5 cycles; no grant to p1 meanwhile; IDLE resumes the cycle after ready=1.
- Reset mid-transaction: rst=1 during RESP → the next cycle shows all rsp_valid=0, mem_en=0, state IDLE, and a fresh request is accepted normally.
- Bounds check (DMEM_ARB_BOUNDS_CHECK_EN):
  - Word load at 0xFE → rsp_err=1, rdata=0, mem_en never 1.
  - Word load at 0xFC → rsp_err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a 256 B little-endian data memory.
// Port 0 (core) has fixed priority; port 1 (loader/debug) is forced through after
// STARVE_LIMIT consecutive denied cycles. One transaction in flight: IDLE -> ACCESS -> RESP.
// Optional feature macro: DMEM_ARB_BOUNDS_CHECK_EN (range/alignment check, err response).
module dmem_arbiter #(
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic              p0_we,
    input  logic [1:0]        p0_dw,
    input  logic              p0_sign,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [31:0]       p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic              p1_we,
    input  logic [1:0]        p1_dw,
    input  logic              p1_sign,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [31:0]       p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_l,
    output logic              mem_s,
    output logic [1:0]        mem_dw,
    output logic              mem_sign,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int AW1   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              owner;
    logic              grant;

    // Captured request (data path, no reset needed: every use is gated by state)
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [1:0]        dw_q;
    logic              sign_q;
    logic [31:0]       rdata_q;

    // Winner's request fields
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_we;
    logic [1:0]        sel_dw;
    logic              sel_sign;

    // Memory is actually touched only for a legal request in ACCESS
    logic              mem_ok;
    logic              acc_mem;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    logic              err_q;

    // Out of range (end past DEPTH) or misaligned for its width
    function automatic logic bounds_err(input logic [ADDR_W-1:0] a, input logic [1:0] dw);
        logic [AW1-1:0] last;
        logic           misalign;
        case (dw)
            2'd0: begin
                last     = {1'b0, a} + AW1'(1);
                misalign = 1'b0;
            end
            2'd1: begin
                last     = {1'b0, a} + AW1'(2);
                misalign = a[0];
            end
            default: begin
                last     = {1'b0, a} + AW1'(4);
                misalign = (a[1:0] != 2'b00);
            end
        endcase
        return misalign || (last > AW1'(DEPTH));
    endfunction

    assign mem_ok = ~err_q;
`else
    assign mem_ok = 1'b1;
`endif

    // Arbitration and next-state logic; grants are only given in IDLE and never during reset
    always_comb begin
        state_nxt    = state;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (p1_req_valid && ((starve_cnt == CNT_MAX) || !p0_req_valid)) begin
                        p1_req_ready = 1'b1;
                        state_nxt    = ACCESS;
                    end else if (p0_req_valid) begin
                        p0_req_ready = 1'b1;
                        state_nxt    = ACCESS;
                    end
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                if (owner ? p1_rsp_ready : p0_rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant     = p0_req_ready | p1_req_ready;
    assign sel_addr  = p1_req_ready ? p1_addr  : p0_addr;
    assign sel_wdata = p1_req_ready ? p1_wdata : p0_wdata;
    assign sel_we    = p1_req_ready ? p1_we    : p0_we;
    assign sel_dw    = p1_req_ready ? p1_dw    : p0_dw;
    assign sel_sign  = p1_req_ready ? p1_sign  : p0_sign;

    // Control state: FSM, owner and port-1 starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant)
                owner <= p1_req_ready;
            if (!p1_req_valid || p1_req_ready)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Request capture on grant, read-data capture at the end of ACCESS
    always_ff @(posedge clk) begin
        if (grant) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            dw_q    <= (sel_dw == 2'd3) ? 2'd2 : sel_dw;
            sign_q  <= sel_sign;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
            err_q   <= bounds_err(sel_addr, sel_dw);
`endif
        end
        if (state == ACCESS)
            rdata_q <= (we_q || !mem_ok) ? 32'd0 : mem_rdata;
    end

    assign acc_mem   = (state == ACCESS) && mem_ok;
    assign mem_en    = acc_mem;
    assign mem_l     = acc_mem & ~we_q;
    assign mem_s     = acc_mem & we_q;
    assign mem_addr  = acc_mem ? addr_q  : '0;
    assign mem_wdata = acc_mem ? wdata_q : 32'd0;
    assign mem_dw    = acc_mem ? dw_q    : 2'd0;
    assign mem_sign  = acc_mem ? sign_q  : 1'b0;

    assign p0_rsp_valid = (state == RESP) && !owner;
    assign p1_rsp_valid = (state == RESP) && owner;
    assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : 32'd0;
    assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : 32'd0;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    assign p0_rsp_err = p0_rsp_valid & err_q;
    assign p1_rsp_err = p1_rsp_valid & err_q;
`else
    assign p0_rsp_err = 1'b0;
    assign p1_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: byte-array memory device, transaction-level reference memory,
// per-cycle starvation model. Honours DMEM_ARB_BOUNDS_CHECK_EN when defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req_valid, p0_req_ready, p0_we, p0_sign, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
    logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
    logic [1:0]  p0_dw;
    logic        p1_req_valid, p1_req_ready, p1_we, p1_sign, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
    logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
    logic [1:0]  p1_dw;
    logic        mem_en, mem_l, mem_s, mem_sign;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_dw;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] dev_mem [0:255];
    logic [7:0] ref_mem [0:255];

    dmem_arbiter #(.DEPTH(256), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_dw(p0_dw), .p0_sign(p0_sign),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_dw(p1_dw), .p1_sign(p1_sign),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_l(mem_l),
        .mem_s(mem_s), .mem_dw(mem_dw), .mem_sign(mem_sign), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory device: combinational read, store committed on negedge
    function automatic logic [7:0] dev_byte(input logic [31:0] a);
        return (a < 32'd256) ? dev_mem[a[7:0]] : 8'h00;
    endfunction

    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = dev_byte(mem_addr);
        b1 = dev_byte(mem_addr + 32'd1);
        b2 = dev_byte(mem_addr + 32'd2);
        b3 = dev_byte(mem_addr + 32'd3);
        case (mem_dw)
            2'd0:    mem_rdata = {{24{mem_sign & b0[7]}}, b0};
            2'd1:    mem_rdata = {{16{mem_sign & b1[7]}}, b1, b0};
            2'd2:    mem_rdata = {b3, b2, b1, b0};
            default: mem_rdata = 32'h0BAD0BAD;
        endcase
    end

    always @(negedge clk) begin
        if (mem_en && mem_s) begin
            for (int i = 0; i < 4; i++) begin
                if ((i == 0 || (i == 1 && mem_dw >= 2'd1) || (i >= 2 && mem_dw == 2'd2)) &&
                    (mem_addr + 32'(i) < 32'd256))
                    dev_mem[8'(mem_addr + 32'(i))] = mem_wdata[8*i +: 8];
            end
        end
    end

    // Reference model of memory contents at transaction level
    function automatic int nbytes(input int dw);
        return (dw == 0) ? 1 : (dw == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input int dw, input bit sg);
        logic [31:0] v;
        int n;
        n = nbytes(dw);
        v = 32'd0;
        for (int i = 0; i < n; i++)
            if (a + i < 256) v[8*i +: 8] = ref_mem[a + i];
        if (sg && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic ref_store(input int a, input int dw, input logic [31:0] wd);
        for (int i = 0; i < nbytes(dw); i++)
            if (a + i < 256) ref_mem[a + i] = wd[8*i +: 8];
    endtask

    // Drive one request and follow it to its response (rsp_ready must already be 1).
    // Called and returns just after a posedge. lat/wt = -1 on timeout.
    task automatic do_txn(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] dw, input bit sg,
                          output logic [31:0] rd, output logic er, output int lat, output int wt,
                          output int en_cnt, output int s_cnt, output logic [1:0] seen_dw);
        rd = 32'd0; er = 1'b0; lat = 0; wt = 0; en_cnt = 0; s_cnt = 0; seen_dw = 2'd0;
        if (!p) begin
            p0_req_valid = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; p0_dw = dw; p0_sign = sg;
        end else begin
            p1_req_valid = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; p1_dw = dw; p1_sign = sg;
        end
        @(negedge clk);
        while (!(p ? p1_req_ready : p0_req_ready) && wt < 40) begin
            wt++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b0;
        if (wt >= 40) begin
            wt = -1; lat = -1;
            return;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_en) begin en_cnt++; seen_dw = mem_dw; end
            if (mem_s) s_cnt++;
            if (p ? p1_rsp_valid : p0_rsp_valid) begin
                lat = c;
                rd  = p ? p1_rsp_rdata : p0_rsp_rdata;
                er  = p ? p1_rsp_err : p0_rsp_err;
                break;
            end
        end
        if (lat == 0) lat = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err,
                         mem_en, mem_l, mem_s, mem_sign, mem_dw} !== 12'd0 ||
                        {p0_rsp_rdata, p1_rsp_rdata, mem_addr, mem_wdata} !== 128'd0) begin
            n_fail++; $display("FAIL reset_outputs: some output nonzero during reset (mem_en=%b rsp_v=%b%b)",
                               mem_en, p0_rsp_valid, p1_rsp_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, mem_en, mem_s, mem_l} !== 7'd0) begin
            n_fail++; $display("FAIL reset_idle: got %b want 0000000",
                               {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, mem_en, mem_s, mem_l});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat, wt, en, sc; logic [1:0] sd;
        do_txn(0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, rd, er, lat, wt, en, sc, sd);
        ref_store(16, 2, 32'hDEADBEEF);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d want 2", lat); end
        n_checks++; if (sc !== 1) begin n_fail++; $display("FAIL store_mem_s_cycles: got %0d want 1", sc); end
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL store_rdata: got %h want 0", rd); end
        do_txn(0, 0, 32'h10, 32'h0, 2'd2, 0, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_word: got %h want deadbeef", rd); end
        n_checks++; if (lat !== 2 || en !== 1 || sc !== 0) begin
            n_fail++; $display("FAIL load_word_timing: lat=%0d en=%0d s=%0d want 2 1 0", lat, en, sc);
        end
        do_txn(0, 0, 32'h10, 32'h0, 2'd0, 1, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (rd !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL load_byte_signed: got %h want ffffffef", rd); end
        do_txn(0, 0, 32'h10, 32'h0, 2'd0, 0, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (rd !== 32'h000000EF) begin n_fail++; $display("FAIL load_byte_unsigned: got %h want 000000ef", rd); end
        do_txn(0, 0, 32'h12, 32'h0, 2'd1, 1, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (rd !== 32'hFFFFDEAD) begin n_fail++; $display("FAIL load_half_signed: got %h want ffffdead", rd); end
        do_txn(1, 0, 32'h10, 32'h0, 2'd3, 0, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (rd !== 32'hDEADBEEF || sd !== 2'd2) begin
            n_fail++; $display("FAIL dw3_as_word: got %h dw=%0d want deadbeef dw=2", rd, sd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp0, exp1;
        exp0 = ref_load(16, 2, 0);
        exp1 = ref_load(16, 1, 1);
        p0_rsp_ready = 1'b0;
        p0_req_valid = 1'b1; p0_we = 0; p0_addr = 32'h10; p0_dw = 2'd2; p0_sign = 0;
        @(negedge clk);
        n_checks++; if (p0_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b want 1", p0_req_ready); end
        @(posedge clk); #1;
        p0_req_valid = 1'b0;
        p1_req_valid = 1'b1; p1_we = 0; p1_addr = 32'h10; p1_dw = 2'd1; p1_sign = 1;
        @(negedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== exp0 || p1_req_ready !== 1'b0 || p1_rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold[%0d]: v=%b d=%h p1rdy=%b want 1 %h 0", k, p0_rsp_valid, p0_rsp_rdata, p1_req_ready, exp0);
            end
            @(posedge clk); #1;
        end
        p0_rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (p0_rsp_valid !== 1'b1 || p1_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: v=%b p1rdy=%b want 1 0", p0_rsp_valid, p1_req_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (p1_req_ready !== 1'b1 || p0_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle_resume: p1rdy=%b p0v=%b want 1 0", p1_req_ready, p0_rsp_valid);
        end
        @(posedge clk); #1;
        p1_req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== exp1 || p0_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_p1_rsp: v=%b d=%h want 1 %h", p1_rsp_valid, p1_rsp_rdata, exp1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bounds();
        logic [31:0] rd; logic er; int lat, wt, en, sc; logic [1:0] sd;
        do_txn(0, 0, 32'hFE, 32'h0, 2'd2, 0, rd, er, lat, wt, en, sc, sd);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        n_checks++; if (er !== 1'b1 || rd !== 32'd0 || en !== 0 || lat !== 2) begin
            n_fail++; $display("FAIL bounds_fe: err=%b rd=%h en=%0d lat=%0d want 1 0 0 2", er, rd, en, lat);
        end
`else
        n_checks++; if (er !== 1'b0 || en !== 1 || lat !== 2) begin
            n_fail++; $display("FAIL nobounds_fe: err=%b en=%0d lat=%0d want 0 1 2", er, en, lat);
        end
`endif
        do_txn(0, 0, 32'hFC, 32'h0, 2'd2, 0, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (er !== 1'b0 || en !== 1 || rd !== ref_load(252, 2, 0)) begin
            n_fail++; $display("FAIL bounds_fc: err=%b en=%0d rd=%h want 0 1 %h", er, en, rd, ref_load(252, 2, 0));
        end
        do_txn(1, 0, 32'hFF, 32'h0, 2'd0, 0, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (er !== 1'b0 || en !== 1) begin n_fail++; $display("FAIL bounds_ff_byte: err=%b en=%0d want 0 1", er, en); end
        do_txn(0, 1, 32'h21, 32'h00001234, 2'd1, 0, rd, er, lat, wt, en, sc, sd);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
        n_checks++; if (er !== 1'b1 || sc !== 0) begin n_fail++; $display("FAIL bounds_misaligned_store: err=%b s=%0d want 1 0", er, sc); end
`else
        ref_store(33, 1, 32'h00001234);
        n_checks++; if (er !== 1'b0 || sc !== 1) begin n_fail++; $display("FAIL nobounds_half_store: err=%b s=%0d want 0 1", er, sc); end
`endif
        do_txn(0, 0, 32'h20, 32'h0, 2'd2, 0, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (rd !== ref_load(32, 2, 0)) begin n_fail++; $display("FAIL bounds_readback: got %h want %h", rd, ref_load(32, 2, 0)); end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, exp; logic er; int lat, wt, en, sc; logic [1:0] sd, dw;
        int a, n; bit p, we, sg;
        for (int t = 0; t < 24; t++) begin
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            dw = 2'($urandom_range(0, 3));
            wd = $urandom;
            n  = nbytes(int'(dw));
            a  = int'($urandom_range(0, 256 - n));
            a  = a - (a % n);
            exp = we ? 32'd0 : ref_load(a, int'(dw), sg);
            do_txn(p, we, 32'(a), wd, dw, sg, rd, er, lat, wt, en, sc, sd);
            if (we) ref_store(a, int'(dw), wd);
            n_checks++; if (rd !== exp || er !== 1'b0) begin
                n_fail++; $display("FAIL rand_data[%0d]: p%0d we=%0d a=%h dw=%0d rd=%h err=%b want %h 0", t, p, we, a, dw, rd, er, exp);
            end
            n_checks++; if (lat !== 2 || en !== 1 || sc !== int'(we) || sd !== ((dw == 2'd3) ? 2'd2 : dw)) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: lat=%0d en=%0d s=%0d dw=%0d", t, lat, en, sc, sd);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_starvation();
        int busy, cnt; bit win, e0, e1;
        p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
        p0_req_valid = 1'b1; p0_we = 0; p0_addr = 32'h10; p0_dw = 2'd2; p0_sign = 0;
        p1_req_valid = 1'b1; p1_we = 0; p1_addr = 32'h20; p1_dw = 2'd2; p1_sign = 0;
        busy = 0; cnt = 0; win = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            e1 = (busy == 0) && (cnt == 4);
            e0 = (busy == 0) && !e1;
            n_checks++; if ({p0_req_ready, p1_req_ready} !== {e0, e1}) begin
                n_fail++; $display("FAIL starve_grant[%0d]: got %b%b want %b%b", c, p0_req_ready, p1_req_ready, e0, e1);
            end
            if (busy == 1) begin
                n_checks++; if ({p0_rsp_valid, p1_rsp_valid} !== (win ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL starve_owner[%0d]: got %b%b want owner p%0d", c, p0_rsp_valid, p1_rsp_valid, win);
                end
            end
            if (busy == 0) begin busy = 2; win = e1; end
            else busy--;
            cnt = e1 ? 0 : ((cnt < 4) ? cnt + 1 : 4);
            @(posedge clk); #1;
        end
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, wt, en, sc; logic [1:0] sd;
        // reset during RESP
        p0_rsp_ready = 1'b0;
        p0_req_valid = 1'b1; p0_we = 0; p0_addr = 32'h10; p0_dw = 2'd2; p0_sign = 0;
        @(negedge clk);
        @(posedge clk); #1;
        p0_req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (p0_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %b want 1", p0_rsp_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        p0_rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({p0_rsp_valid, p1_rsp_valid, mem_en} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_resp_drop: got %b want 000", {p0_rsp_valid, p1_rsp_valid, mem_en});
        end
        @(posedge clk); #1;
        do_txn(0, 0, 32'h10, 32'h0, 2'd0, 1, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (wt !== 0 || lat !== 2 || rd !== ref_load(16, 0, 1)) begin
            n_fail++; $display("FAIL rstmid_fresh: wait=%0d lat=%0d rd=%h want 0 2 %h", wt, lat, rd, ref_load(16, 0, 1));
        end
        // reset during ACCESS of a store: the store still lands, strobes drop next cycle
        p0_req_valid = 1'b1; p0_we = 1; p0_addr = 32'h30; p0_wdata = 32'hA5C3_1E77; p0_dw = 2'd2; p0_sign = 0;
        @(negedge clk);
        @(posedge clk); #1;
        p0_req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_s !== 1'b1) begin n_fail++; $display("FAIL rstacc_store_strobe: got %b want 1", mem_s); end
        @(posedge clk); #1;
        rst = 1'b0;
        ref_store(48, 2, 32'hA5C3_1E77);
        @(negedge clk);
        n_checks++; if ({mem_en, mem_s, mem_l, p0_rsp_valid} !== 4'b0000) begin
            n_fail++; $display("FAIL rstacc_strobes: got %b want 0000", {mem_en, mem_s, mem_l, p0_rsp_valid});
        end
        @(posedge clk); #1;
        do_txn(1, 0, 32'h30, 32'h0, 2'd2, 0, rd, er, lat, wt, en, sc, sd);
        n_checks++; if (rd !== 32'hA5C3_1E77) begin n_fail++; $display("FAIL rstacc_readback: got %h want a5c31e77", rd); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            dev_mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        rst = 1'b1;
        p0_req_valid = 0; p0_addr = 0; p0_wdata = 0; p0_we = 0; p0_dw = 0; p0_sign = 0; p0_rsp_ready = 1;
        p1_req_valid = 0; p1_addr = 0; p1_wdata = 0; p1_we = 0; p1_dw = 0; p1_sign = 0; p1_rsp_ready = 1;
        @(posedge clk); #1;
        test_reset();
        test_store_load();
        test_backpressure();
        test_bounds();
        test_random();
        test_starvation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
